// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_BYTES      = 4;
    localparam int unsigned ADDR_W         = 32;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        WRITE,
        DONE,
        ERR
    } loader_state_e;

    // Byte address of word idx counted from base.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] idx);
        return base + idx * ADDR_W'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Collects N_BYTES little-endian bytes into one word; the completed word is presented
// combinationally together with the accepting byte so the caller can register it on that edge.
module imem_loader_byte_assembler
    import imem_loader_pkg::*;
#(
    parameter int unsigned N_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        byte_en,
    input  logic [BYTE_W-1:0]           byte_in,
    output logic [N_BYTES*BYTE_W-1:0]   word_c,
    output logic                        word_valid_c
);

    localparam int unsigned CNT_W  = $clog2(N_BYTES);
    localparam int unsigned WORD_W = N_BYTES * BYTE_W;
    localparam int unsigned SHR_W  = WORD_W - BYTE_W;

    logic [CNT_W-1:0] byte_idx;
    logic [SHR_W-1:0] shreg;

    // Newest byte lands on top, so the first byte received ends up in bits [7:0].
    assign word_c       = {byte_in, shreg};
    assign word_valid_c = byte_en && (byte_idx == CNT_W'(N_BYTES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx <= '0;
            shreg    <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            shreg    <= '0;
        end else if (byte_en) begin
            shreg    <= word_c[WORD_W-1:BYTE_W];
            byte_idx <= word_valid_c ? '0 : byte_idx + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte image into instruction memory and holds the
// core in reset until the whole image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       DEPTH     = 1024,
    parameter int unsigned       WIDTH     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WIDTH-1:0]  imem_wdata,
    output logic              core_hold,
    output logic [ADDR_W-1:0] boot_address,
    output logic              load_done,
    output logic              load_error
);

    localparam int unsigned IDX_W  = $clog2(DEPTH + 1);
    localparam int unsigned WORD_W = HDR_BYTES * BYTE_W;

    loader_state_e     state_q;
    logic [IDX_W-1:0]  word_idx;
    logic [WORD_W-1:0] count;
    logic              rx_ready_q;

    logic              xfer;
    logic [WORD_W-1:0] asm_word_c;
    logic              asm_valid_c;

    // start wins over any byte offered in the same cycle.
    assign rx_ready     = rx_ready_q & ~start;
    assign xfer         = rx_valid & rx_ready;
    assign boot_address = BASE_ADDR;

    // Header and data words share one assembler since both are four bytes long.
    imem_loader_byte_assembler #(
        .N_BYTES (HDR_BYTES)
    ) u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear        (start),
        .byte_en      (xfer),
        .byte_in      (rx_data),
        .word_c       (asm_word_c),
        .word_valid_c (asm_valid_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HDR;
            word_idx   <= '0;
            count      <= '0;
            rx_ready_q <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                state_q    <= HDR;
                word_idx   <= '0;
                count      <= '0;
                rx_ready_q <= 1'b1;
                core_hold  <= 1'b1;
                load_done  <= 1'b0;
                load_error <= 1'b0;
            end else begin
                case (state_q)
                    HDR: begin
                        if (asm_valid_c) begin
                            count <= asm_word_c;
                            if (asm_word_c == '0) begin
                                state_q    <= DONE;
                                rx_ready_q <= 1'b0;
                                core_hold  <= 1'b0;
                                load_done  <= 1'b1;
                            end else if (asm_word_c > WORD_W'(DEPTH)) begin
                                state_q    <= ERR;
                                rx_ready_q <= 1'b0;
                                load_error <= 1'b1;
                            end else begin
                                state_q <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (asm_valid_c) begin
                            state_q    <= WRITE;
                            rx_ready_q <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_addr  <= word_addr(BASE_ADDR, ADDR_W'(word_idx));
                            imem_wdata <= WIDTH'(asm_word_c);
                        end
                    end
                    WRITE: begin
                        word_idx <= word_idx + IDX_W'(1);
                        if (WORD_W'(word_idx) + WORD_W'(1) == count) begin
                            state_q    <= DONE;
                            core_hold  <= 1'b0;
                            load_done  <= 1'b1;
                        end else begin
                            state_q    <= DATA;
                            rx_ready_q <= 1'b1;
                        end
                    end
                    DONE, ERR: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q <= HDR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random images against a list-based model of the expected writes.
module tb_imem_loader;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic [31:0] boot_address;
    logic        load_done;
    logic        load_error;

    imem_loader #(.DEPTH(DEPTH), .WIDTH(32), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .boot_address (boot_address),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    wr_t wr_q[$];
    always @(negedge clk) if (imem_we === 1'b1) wr_q.push_back('{imem_addr, imem_wdata, cyc});

    int          passed = 0;
    int          total  = 0;
    bit          timed_out;
    int unsigned last_acc;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done;
    bit          exp_err;
    logic [31:0] words[$];

    // Reference: what the image format says should land in memory.
    task automatic build_expect(input logic [31:0] n);
        exp_addr.delete();
        exp_data.delete();
        exp_err  = (n > DEPTH);
        exp_done = !exp_err;
        if (!exp_err)
            for (int i = 0; i < int'(n); i++) begin
                exp_addr.push_back(BASE + 32'(4 * i));
                exp_data.push_back(words[i]);
            end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        while (rx_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (rx_ready !== 1'b1) timed_out = 1'b1;
        else begin
            last_acc = cyc + 1;
            @(posedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_gap);
    endtask

    task automatic do_start();
        @(negedge clk);
        start    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wr_q.delete();
        timed_out = 1'b0;
    endtask

    task automatic load_image(input logic [31:0] n, input int max_gap);
        do_start();
        send_word(n, max_gap);
        if (n > 0 && n <= DEPTH)
            for (int i = 0; i < int'(n); i++) send_word(words[i], max_gap);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        build_expect(n);
    endtask

    task automatic random_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        total++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready got %b exp 1", rx_ready); else passed++;
        total++; if (imem_we !== 1'b0) $display("FAIL reset_we got %b exp 0", imem_we); else passed++;
        total++; if (imem_addr !== BASE) $display("FAIL reset_addr got %h exp %h", imem_addr, BASE); else passed++;
        total++; if (imem_wdata !== 32'h0) $display("FAIL reset_wdata got %h exp 0", imem_wdata); else passed++;
        total++; if (core_hold !== 1'b1) $display("FAIL reset_hold got %b exp 1", core_hold); else passed++;
        total++; if (load_done !== 1'b0) $display("FAIL reset_done got %b exp 0", load_done); else passed++;
        total++; if (load_error !== 1'b0) $display("FAIL reset_err got %b exp 0", load_error); else passed++;
        total++; if (boot_address !== BASE) $display("FAIL boot_addr got %h exp %h", boot_address, BASE); else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        words.delete();
        words.push_back(32'h0000_0013);
        words.push_back(32'h0050_0093);
        load_image(32'd2, 0);
        total++; if (timed_out !== 1'b0) $display("FAIL basic_timeout got %b exp 0", timed_out); else passed++;
        total++; if (wr_q.size() !== exp_addr.size()) $display("FAIL basic_count got %0d exp %0d", wr_q.size(), exp_addr.size()); else passed++;
        foreach (exp_addr[i]) if (i < wr_q.size()) begin
            total++;
            if ({wr_q[i].addr, wr_q[i].data} !== {exp_addr[i], exp_data[i]})
                $display("FAIL basic_wr%0d got %h/%h exp %h/%h", i, wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
            else passed++;
        end
        if (wr_q.size() > 0) begin
            total++;
            if (wr_q[wr_q.size()-1].cyc !== last_acc)
                $display("FAIL basic_latency got cyc %0d exp %0d", wr_q[wr_q.size()-1].cyc, last_acc);
            else passed++;
        end
        total++; if (load_done !== exp_done) $display("FAIL basic_done got %b exp %b", load_done, exp_done); else passed++;
        total++; if (core_hold !== 1'b0) $display("FAIL basic_hold got %b exp 0", core_hold); else passed++;
        total++; if (rx_ready !== 1'b0) $display("FAIL basic_rx_ready got %b exp 0", rx_ready); else passed++;
    endtask

    task automatic test_zero();
        do_start();
        send_word(32'd0, 0);
        #1;
        total++; if (load_done !== 1'b1) $display("FAIL zero_done_now got %b exp 1", load_done); else passed++;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (wr_q.size() !== 0) $display("FAIL zero_writes got %0d exp 0", wr_q.size()); else passed++;
        total++; if (rx_ready !== 1'b0) $display("FAIL zero_rx_ready got %b exp 0", rx_ready); else passed++;
        total++; if (core_hold !== 1'b0) $display("FAIL zero_hold got %b exp 0", core_hold); else passed++;
        total++; if (load_error !== 1'b0) $display("FAIL zero_err got %b exp 0", load_error); else passed++;
    endtask

    task automatic test_error();
        logic [31:0] bad [2];
        bad[0] = 32'(DEPTH + 1);
        bad[1] = 32'h8000_0000 | $urandom;
        for (int k = 0; k < 2; k++) begin
            words.delete();
            load_image(bad[k], 0);
            total++; if (load_error !== exp_err) $display("FAIL err%0d_flag got %b exp %b", k, load_error, exp_err); else passed++;
            total++; if (load_done !== 1'b0) $display("FAIL err%0d_done got %b exp 0", k, load_done); else passed++;
            total++; if (core_hold !== 1'b1) $display("FAIL err%0d_hold got %b exp 1", k, core_hold); else passed++;
            total++; if (rx_ready !== 1'b0) $display("FAIL err%0d_rx_ready got %b exp 0", k, rx_ready); else passed++;
            total++; if (wr_q.size() !== 0) $display("FAIL err%0d_writes got %0d exp 0", k, wr_q.size()); else passed++;
        end
        do_start();
        #1;
        total++; if (load_error !== 1'b0) $display("FAIL err_clear got %b exp 0", load_error); else passed++;
        total++; if (rx_ready !== 1'b1) $display("FAIL err_restart_ready got %b exp 1", rx_ready); else passed++;
    endtask

    task automatic test_gaps();
        int n;
        for (int pass = 0; pass < 2; pass++) begin
            n = int'($urandom_range(6, 3));
            random_words(n);
            load_image(32'(n), (pass == 0) ? 3 : 0);
            total++; if (timed_out !== 1'b0) $display("FAIL gap%0d_timeout got %b exp 0", pass, timed_out); else passed++;
            total++; if (wr_q.size() !== exp_addr.size()) $display("FAIL gap%0d_count got %0d exp %0d", pass, wr_q.size(), exp_addr.size()); else passed++;
            foreach (exp_addr[i]) if (i < wr_q.size()) begin
                total++;
                if ({wr_q[i].addr, wr_q[i].data} !== {exp_addr[i], exp_data[i]})
                    $display("FAIL gap%0d_wr%0d got %h/%h exp %h/%h", pass, i, wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
                else passed++;
            end
            total++; if (load_done !== exp_done) $display("FAIL gap%0d_done got %b exp %b", pass, load_done, exp_done); else passed++;
        end
    endtask

    task automatic test_max();
        int bad_wr;
        random_words(DEPTH);
        load_image(32'(DEPTH), 0);
        total++; if (timed_out !== 1'b0) $display("FAIL max_timeout got %b exp 0", timed_out); else passed++;
        total++; if (wr_q.size() !== exp_addr.size()) $display("FAIL max_count got %0d exp %0d", wr_q.size(), exp_addr.size()); else passed++;
        bad_wr = 0;
        foreach (exp_addr[i]) if (i < wr_q.size()) begin
            total++;
            if ({wr_q[i].addr, wr_q[i].data} !== {exp_addr[i], exp_data[i]}) begin
                if (bad_wr < 4) $display("FAIL max_wr%0d got %h/%h exp %h/%h", i, wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
                bad_wr++;
            end else passed++;
        end
        if (wr_q.size() > 0) begin
            total++;
            if (wr_q[wr_q.size()-1].addr !== BASE + 32'(4 * (DEPTH - 1)))
                $display("FAIL max_last_addr got %h exp %h", wr_q[wr_q.size()-1].addr, BASE + 32'(4 * (DEPTH - 1)));
            else passed++;
        end
        total++; if (load_done !== 1'b1) $display("FAIL max_done got %b exp 1", load_done); else passed++;
        total++; if (load_error !== 1'b0) $display("FAIL max_err got %b exp 0", load_error); else passed++;
    endtask

    task automatic test_abort();
        do_start();
        send_word(32'd3, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clk);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hCC;
        #1;
        total++; if (rx_ready !== 1'b0) $display("FAIL abort_rx_ready got %b exp 0", rx_ready); else passed++;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        total++; if (core_hold !== 1'b1) $display("FAIL abort_hold got %b exp 1", core_hold); else passed++;
        total++; if (load_done !== 1'b0) $display("FAIL abort_done got %b exp 0", load_done); else passed++;
        random_words(1);
        send_word(32'd1, 0);
        send_word(words[0], 0);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        build_expect(32'd1);
        total++; if (wr_q.size() !== 1) $display("FAIL abort_count got %0d exp 1", wr_q.size()); else passed++;
        if (wr_q.size() > 0) begin
            total++;
            if ({wr_q[0].addr, wr_q[0].data} !== {exp_addr[0], exp_data[0]})
                $display("FAIL abort_wr got %h/%h exp %h/%h", wr_q[0].addr, wr_q[0].data, exp_addr[0], exp_data[0]);
            else passed++;
        end
        total++; if (load_done !== 1'b1) $display("FAIL abort_redone got %b exp 1", load_done); else passed++;
    endtask

    task automatic test_async_reset();
        random_words(2);
        do_start();
        send_word(32'd2, 0);
        send_word(words[0], 0);
        #1;
        total++; if (imem_we !== 1'b1) $display("FAIL ar_we_before got %b exp 1", imem_we); else passed++;
        #1;
        reset = 1'b1;
        #1;
        total++; if (imem_we !== 1'b0) $display("FAIL ar_we got %b exp 0", imem_we); else passed++;
        total++; if (rx_ready !== 1'b1) $display("FAIL ar_rx_ready got %b exp 1", rx_ready); else passed++;
        total++; if (imem_addr !== BASE) $display("FAIL ar_addr got %h exp %h", imem_addr, BASE); else passed++;
        total++; if (imem_wdata !== 32'h0) $display("FAIL ar_wdata got %h exp 0", imem_wdata); else passed++;
        total++; if (core_hold !== 1'b1) $display("FAIL ar_hold got %b exp 1", core_hold); else passed++;
        total++; if (load_done !== 1'b0) $display("FAIL ar_done got %b exp 0", load_done); else passed++;
        total++; if (load_error !== 1'b0) $display("FAIL ar_err got %b exp 0", load_error); else passed++;
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        timed_out = 1'b0;
        last_acc  = 0;
        test_reset();
        test_basic();
        test_zero();
        test_error();
        test_gaps();
        test_max();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
